// File: rtl/freq_cfg_pkg.sv
// Shared types and preset table for the frequency configuration sequencer.
package freq_cfg_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STROBE, SETTLE} state_t;

    localparam int DEF_WORD_W = 16;
    localparam int TABLE_DEPTH = 4;

    localparam logic [DEF_WORD_W-1:0] PRESET_TABLE [TABLE_DEPTH] =
        '{16'h0100, 16'h0200, 16'h0400, 16'h0800};

    function automatic logic [DEF_WORD_W-1:0] preset_word(input logic [1:0] idx);
        return PRESET_TABLE[idx];
    endfunction

endpackage

// File: rtl/freq_word_serializer.sv
// Parallel-load PISO: shifts a frequency word out MSB first, one bit per shift_en.
module freq_word_serializer
    import freq_cfg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift_en,
    output logic              bit_out,
    output logic              done
);

    localparam int BC_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              bit_q, bit_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        bit_d     = bit_q;
        if (load) begin
            bit_d     = word[WORD_W-1];
            shreg_d   = {word[WORD_W-2:0], 1'b0};
            bit_cnt_d = BC_W'(WORD_W - 1);
        end else if (shift_en) begin
            // The shift that ends the last bit returns the line to idle low.
            if (bit_cnt_q == '0) begin
                bit_d = 1'b0;
            end else begin
                bit_d     = shreg_q[WORD_W-1];
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            bit_q     <= bit_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign bit_out = bit_q;
    assign done    = (bit_cnt_q == '0);

endmodule

// File: rtl/freq_cfg_sequencer.sv
// Preset selection and serial load sequencing for the clock manager frequency input.
// Optional AUTO_SWEEP_EN build adds a periodic step-and-load sweep through the presets.
module freq_cfg_sequencer
    import freq_cfg_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int NUM_PRESETS = 4,
    parameter int BIT_DIV     = 4,
    parameter int STROBE_LEN  = 2,
    parameter int SETTLE_LEN  = 64
`ifdef AUTO_SWEEP_EN
    ,
    parameter int SWEEP_PERIOD = 2**20
`endif
) (
    input  logic                           sysclk,
    input  logic                           reset,
    input  logic                           step_req,
    input  logic                           load_req,
    output logic                           FreqData,
    output logic                           NewDataReady,
    output logic [$clog2(NUM_PRESETS)-1:0] sel,
    output logic                           busy
);

    localparam int SW      = $clog2(NUM_PRESETS);
    localparam int MAX_A   = (BIT_DIV > STROBE_LEN) ? BIT_DIV : STROBE_LEN;
    localparam int MAX_CNT = (MAX_A > SETTLE_LEN) ? MAX_A : SETTLE_LEN;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] BIT_RELOAD    = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] STROBE_RELOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
    localparam logic [SW-1:0]    LAST_SEL      = SW'(NUM_PRESETS - 1);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            pending_q, pending_d;
    logic            boot_q, boot_d;
    logic            ndr_q, ndr_d;
    logic            busy_q, busy_d;

    logic            shift_en;
    logic            ser_bit;
    logic            ser_last;
    logic            sweep_step;
    logic            sweep_load;
    logic            start;
    logic [WORD_W-1:0] load_word;

    assign load_word = WORD_W'(preset_word(2'(sel_q)));

    freq_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk      (sysclk),
        .reset    (reset),
        .load     (state_q == LOAD),
        .word     (load_word),
        .shift_en (shift_en),
        .bit_out  (ser_bit),
        .done     (ser_last)
    );

`ifdef AUTO_SWEEP_EN
    localparam int SWP_W = $clog2(SWEEP_PERIOD);

    logic [SWP_W-1:0] swp_cnt_q, swp_cnt_d;
    logic             swp_ld_q, swp_ld_d;

    // Counter only advances while idle, so a sweep step never lands mid-transfer.
    always_comb begin
        swp_cnt_d  = swp_cnt_q;
        swp_ld_d   = 1'b0;
        sweep_step = 1'b0;
        if (!busy_q) begin
            if (swp_cnt_q == SWP_W'(SWEEP_PERIOD - 1)) begin
                swp_cnt_d  = '0;
                sweep_step = 1'b1;
                swp_ld_d   = 1'b1;
            end else begin
                swp_cnt_d = swp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            swp_cnt_q <= '0;
            swp_ld_q  <= 1'b0;
        end else begin
            swp_cnt_q <= swp_cnt_d;
            swp_ld_q  <= swp_ld_d;
        end
    end

    assign sweep_load = swp_ld_q;
`else
    assign sweep_step = 1'b0;
    assign sweep_load = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ndr_d     = ndr_q;
        busy_d    = busy_q;
        boot_d    = 1'b0;
        shift_en  = 1'b0;
        start     = load_req | pending_q | boot_q | sweep_load;

        sel_d = sel_q;
        if (step_req || sweep_step) begin
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = BIT_RELOAD;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    shift_en = 1'b1;
                    if (ser_last) begin
                        state_d = STROBE;
                        cnt_d   = STROBE_RELOAD;
                        ndr_d   = 1'b1;
                    end else begin
                        cnt_d = BIT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    ndr_d = 1'b0;
                    if (SETTLE_LEN == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-transfer collapse into one deferred load.
        if (load_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            pending_q <= 1'b0;
            boot_q    <= 1'b1;
            ndr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            boot_q    <= boot_d;
            ndr_q     <= ndr_d;
            busy_q    <= busy_d;
        end
    end

    assign FreqData     = ser_bit;
    assign NewDataReady = ndr_q;
    assign sel          = sel_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_freq_cfg_sequencer.sv
// Scoreboard bench for freq_cfg_sequencer: expected words queued at request, checked per transfer.
`timescale 1ns/1ps
module tb_freq_cfg_sequencer;

    // Transfer length in cycles from LOAD to busy low: LOAD + 16 bits x 4 + strobe 2 + settle 64.
    localparam int XFER_LEN = 1 + 16 * 4 + 2 + 64;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       step_req = 1'b0;
    logic       load_req = 1'b0;
    logic       FreqData;
    logic       NewDataReady;
    logic [1:0] sel;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] word;
        bit          ndr_ok;
        bit          hold_ok;
        int          len;
    } obs_t;

    logic [15:0] exp_q[$];
    obs_t        obs_q[$];

    always #5 sysclk = ~sysclk;

`ifdef AUTO_SWEEP_EN
    freq_cfg_sequencer #(.SWEEP_PERIOD(200)) dut (
`else
    freq_cfg_sequencer dut (
`endif
        .sysclk       (sysclk),
        .reset        (reset),
        .step_req     (step_req),
        .load_req     (load_req),
        .FreqData     (FreqData),
        .NewDataReady (NewDataReady),
        .sel          (sel),
        .busy         (busy)
    );

    // Transfer monitor: k=0 is the LOAD cycle; bits occupy k=1..64 in 4-cycle cells.
    bit          mon_active = 0;
    int          mon_k = 0;
    logic [15:0] mon_word = '0;
    logic        mon_cur = 1'b0;
    bit          mon_ndr_ok = 1;
    bit          mon_hold_ok = 1;
    obs_t        mon_o;

    always @(negedge sysclk) begin
        if (reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (busy === 1'b1) begin
                mon_active  = 1;
                mon_k       = 0;
                mon_word    = '0;
                mon_cur     = 1'b0;
                mon_ndr_ok  = (NewDataReady === 1'b0);
                mon_hold_ok = (FreqData === 1'b0);
            end
        end else begin
            mon_k = mon_k + 1;
            if (mon_k <= 64) begin
                if ((mon_k - 1) % 4 == 0) mon_cur = FreqData;
                else if (FreqData !== mon_cur) mon_hold_ok = 0;
                if ((mon_k - 1) % 4 == 3) mon_word = {mon_word[14:0], mon_cur};
            end else if (FreqData !== 1'b0) begin
                mon_hold_ok = 0;
            end
            if (NewDataReady !== ((mon_k == 65) || (mon_k == 66))) mon_ndr_ok = 0;
            if (busy !== 1'b1 || mon_k > 1000) begin
                mon_o.word    = mon_word;
                mon_o.ndr_ok  = mon_ndr_ok;
                mon_o.hold_ok = mon_hold_ok;
                mon_o.len     = mon_k;
                obs_q.push_back(mon_o);
                mon_active = 0;
            end
        end
    end

    task automatic pulse(input bit s, input bit l);
        step_req = s;
        load_req = l;
        @(negedge sysclk);
        step_req = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic wait_obs(input int budget, output bit got);
        got = 0;
        for (int c = 0; c < budget; c++) begin
            if (obs_q.size() > 0) begin
                got = 1;
                break;
            end
            @(negedge sysclk);
        end
        if (obs_q.size() > 0) got = 1;
    endtask

    task automatic test_reset();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++; if (FreqData !== 1'b0) begin errors++; $display("FAIL reset_freqdata: got %b expected 0", FreqData); end
        checks++; if (NewDataReady !== 1'b0) begin errors++; $display("FAIL reset_ndr: got %b expected 0", NewDataReady); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        exp_q.push_back(16'h0100);
        reset = 1'b0;
        wait_obs(400, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL auto_load_timeout: got no transfer expected one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.word !== e) begin errors++; $display("FAIL auto_load_word: got %h expected %h", o.word, e); end
            checks++;
            if (!o.ndr_ok || !o.hold_ok || o.len != XFER_LEN) begin
                errors++; $display("FAIL auto_load_timing: got ndr_ok=%0d hold_ok=%0d len=%0d expected 1 1 %0d", o.ndr_ok, o.hold_ok, o.len, XFER_LEN);
            end
        end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL auto_load_sel: got %0d expected 0", sel); end
    endtask

    task automatic test_step_wrap();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        repeat (3) pulse(1, 0);
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL step3_sel: got %0d expected 3", sel); end
        exp_q.push_back(16'h0800);
        pulse(0, 1);
        wait_obs(400, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL step3_timeout: got no transfer expected one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.word !== e) begin errors++; $display("FAIL step3_word: got %h expected %h", o.word, e); end
            checks++;
            if (!o.ndr_ok || !o.hold_ok || o.len != XFER_LEN) begin
                errors++; $display("FAIL step3_timing: got ndr_ok=%0d hold_ok=%0d len=%0d expected 1 1 %0d", o.ndr_ok, o.hold_ok, o.len, XFER_LEN);
            end
        end
        pulse(1, 0);
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL step_wrap_sel: got %0d expected 0", sel); end
    endtask

    task automatic test_same_cycle();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        pulse(1, 0);
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL same_pre_sel: got %0d expected 1", sel); end
        exp_q.push_back(16'h0400);
        pulse(1, 1);
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL same_sel: got %0d expected 2", sel); end
        wait_obs(400, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL same_timeout: got no transfer expected one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.word !== e) begin errors++; $display("FAIL same_word: got %h expected %h", o.word, e); end
        end
    endtask

    task automatic test_pending();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        exp_q.push_back(16'h0400);
        pulse(0, 1);
        repeat (10) @(negedge sysclk);
        repeat (3) pulse(0, 1);
        // Step mid-transfer: the in-flight word keeps sel=2, the deferred load uses sel=3.
        pulse(1, 0);
        checks++; if (sel !== 2'd3) begin errors++; $display("FAIL pend_sel: got %0d expected 3", sel); end
        exp_q.push_back(16'h0800);
        for (int n = 0; n < 2; n++) begin
            wait_obs(400, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL pend_timeout%0d: got no transfer expected one", n);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o.word !== e) begin errors++; $display("FAIL pend_word%0d: got %h expected %h", n, o.word, e); end
                checks++;
                if (!o.ndr_ok || !o.hold_ok || o.len != XFER_LEN) begin
                    errors++; $display("FAIL pend_timing%0d: got ndr_ok=%0d hold_ok=%0d len=%0d expected 1 1 %0d", n, o.ndr_ok, o.hold_ok, o.len, XFER_LEN);
                end
            end
        end
        repeat (300) @(negedge sysclk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pend_extra: got %0d extra transfers expected 0", obs_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        pulse(0, 1);
        repeat (38) @(negedge sysclk);
        #1 reset = 1'b1;
        #1;
        checks++; if (FreqData !== 1'b0) begin errors++; $display("FAIL abort_freqdata: got %b expected 0", FreqData); end
        checks++; if (NewDataReady !== 1'b0) begin errors++; $display("FAIL abort_ndr: got %b expected 0", NewDataReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL abort_sel: got %0d expected 0", sel); end
        @(negedge sysclk);
        @(negedge sysclk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_partial: got %0d transfers expected 0", obs_q.size()); end
        exp_q.push_back(16'h0100);
        reset = 1'b0;
        wait_obs(400, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL reload_timeout: got no transfer expected one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.word !== e) begin errors++; $display("FAIL reload_word: got %h expected %h", o.word, e); end
            checks++;
            if (!o.ndr_ok || !o.hold_ok || o.len != XFER_LEN) begin
                errors++; $display("FAIL reload_timing: got ndr_ok=%0d hold_ok=%0d len=%0d expected 1 1 %0d", o.ndr_ok, o.hold_ok, o.len, XFER_LEN);
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    endtask

`ifdef AUTO_SWEEP_EN
    task automatic test_sweep();
        bit          got;
        obs_t        o;
        logic [15:0] e;
        int          strobes = 0;
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0400);
        exp_q.push_back(16'h0800);
        exp_q.push_back(16'h0100);
        for (int n = 0; n < 4; n++) begin
            wait_obs(800, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL sweep_timeout%0d: got no transfer expected one", n);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o.ndr_ok) strobes++;
                if (o.word !== e) begin errors++; $display("FAIL sweep_word%0d: got %h expected %h", n, o.word, e); end
            end
        end
        checks++; if (strobes != 4) begin errors++; $display("FAIL sweep_strobes: got %0d expected 4", strobes); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL sweep_sel: got %0d expected 0", sel); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_SWEEP_EN
        test_sweep();
`else
        test_step_wrap();
        test_same_cycle();
        test_pending();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before 400000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
